irr_isr_priority_resolver: RTL and testbench

- Request-side stage of the 8259A model; sits directly upstream of the control logic block.
- Synchronises the eight IR pins and holds the interrupt request register (IRR) with edge/level detection.
- Holds the in-service register (ISR) and resolves rotating priority, fully-nested or special-fully-nested.
- Outputs to the control logic: the one-hot winning request `interrupt` and `highest_level_in_service`. Inputs from the control logic: mask, rotate, latch, clear and EOI commands.

---
 rtl/irr_isr_priority_resolver.sv | 135 +++++++++++++
 tb/tb_irr_isr_priority_resolver.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irr_isr_priority_resolver.sv
// 8259A request stage: IR pin synchroniser, IRR with edge/level detect, ISR and priority resolution.
// Optional SPECIAL_MASK_MODE_EN adds the special_mask_mode input.
module irr_isr_priority_resolver #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] interrupt_request_pin,
  input  logic       level_or_edge_toriggered_config,
  input  logic       special_fully_nest_config,
  input  logic       freeze,
  input  logic [7:0] interrupt_mask,
  input  logic [2:0] priority_rotate,
  input  logic       latch_in_service,
  input  logic [7:0] clear_interrupt_request,
  input  logic [7:0] end_of_interrupt,
`ifdef SPECIAL_MASK_MODE_EN
  input  logic       special_mask_mode,
`endif
  output logic [7:0] interrupt,
  output logic [7:0] highest_level_in_service,
  output logic [7:0] interrupt_request_register,
  output logic [7:0] in_service_register
);

  localparam int unsigned NUM_IR = 8;
  localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0][NUM_IR-1:0] sync_q;
  logic [NUM_IR-1:0] s;
  logic [NUM_IR-1:0] prev;
  logic [NUM_IR-1:0] rise;
  logic [NUM_IR-1:0] irr;
  logic [NUM_IR-1:0] irr_next;
  logic [NUM_IR-1:0] isr;
  logic [NUM_IR-1:0] isr_next;
  logic [NUM_IR-1:0] masked_req;
  logic [NUM_IR-1:0] candidates;
  logic [NUM_IR-1:0] winner;
  logic [NUM_IR-1:0] hlis;
  logic [NUM_IR-1:0] grant;
  logic              smm;

`ifdef SPECIAL_MASK_MODE_EN
  assign smm = special_mask_mode;
`else
  assign smm = 1'b0;
`endif

  // Highest-priority set bit of v; the level after priority_rotate is highest.
  function automatic logic [7:0] pick(input logic [7:0] v, input logic [2:0] rot);
    logic [7:0] r;
    logic       found;
    logic [2:0] idx;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = 3'(rot + 3'd1 + 3'(i));
      if (!found && v[idx]) begin
        r[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return r;
  endfunction

  // Priority rank of a one-hot level, 0 = highest.
  function automatic logic [2:0] rank(input logic [7:0] oh, input logic [2:0] rot);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return 3'(idx - rot - 3'd1);
  endfunction

  assign s    = sync_q[STAGES-1];
  assign rise = s & ~prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev   <= '0;
      irr    <= '0;
      isr    <= '0;
    end else begin
      sync_q[0] <= interrupt_request_pin;
      for (int i = 1; i < int'(STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev <= s;
      irr  <= irr_next;
      isr  <= isr_next;
    end
  end

  // Clear beats freeze, freeze beats set; level mode tracks the synced pin.
  always_comb begin
    irr_next = level_or_edge_toriggered_config ? s : (irr | rise);
    if (freeze) irr_next = irr;
    irr_next = irr_next & ~clear_interrupt_request;
  end

  always_comb begin
    masked_req = irr & ~interrupt_mask;
    candidates = masked_req;
    hlis       = pick(isr, priority_rotate);
    grant      = '0;
    if (smm) begin
      hlis       = pick(isr & ~interrupt_mask, priority_rotate);
      candidates = masked_req & ~isr;
    end
    winner = pick(candidates, priority_rotate);
    if (smm || (hlis == '0)) begin
      grant = winner;
    end else if (rank(winner, priority_rotate) < rank(hlis, priority_rotate)) begin
      grant = winner;
    end else if (special_fully_nest_config &&
                 (rank(winner, priority_rotate) == rank(hlis, priority_rotate))) begin
      grant = winner;
    end
  end

  // Latch set wins over EOI on the same bit.
  always_comb begin
    isr_next = isr & ~end_of_interrupt;
    if (latch_in_service) isr_next = isr_next | grant;
  end

  assign interrupt                  = grant;
  assign highest_level_in_service   = hlis;
  assign interrupt_request_register = irr;
  assign in_service_register        = isr;

endmodule

// File: tb/tb_irr_isr_priority_resolver.sv
// Directed self-checking bench for irr_isr_priority_resolver.
module tb_irr_isr_priority_resolver;

  logic       clock;
  logic       reset;
  logic [7:0] pin;
  logic       level;
  logic       sfnm;
  logic       freeze;
  logic [7:0] mask;
  logic [2:0] rotate;
  logic       latch;
  logic [7:0] clr;
  logic [7:0] eoi;
`ifdef SPECIAL_MASK_MODE_EN
  logic       smm;
`endif
  logic [7:0] interrupt;
  logic [7:0] hlis;
  logic [7:0] irr;
  logic [7:0] isr;

  int checks;
  int failures;

  irr_isr_priority_resolver #(.SYNC_STAGES(2)) dut (
    .clock                           (clock),
    .reset                           (reset),
    .interrupt_request_pin           (pin),
    .level_or_edge_toriggered_config (level),
    .special_fully_nest_config       (sfnm),
    .freeze                          (freeze),
    .interrupt_mask                  (mask),
    .priority_rotate                 (rotate),
    .latch_in_service                (latch),
    .clear_interrupt_request         (clr),
    .end_of_interrupt                (eoi),
`ifdef SPECIAL_MASK_MODE_EN
    .special_mask_mode               (smm),
`endif
    .interrupt                       (interrupt),
    .highest_level_in_service        (hlis),
    .interrupt_request_register      (irr),
    .in_service_register             (isr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; pin = '0; level = 1'b0; sfnm = 1'b0; freeze = 1'b0;
    mask = '0; rotate = 3'd7; latch = 1'b0; clr = '0; eoi = '0;
`ifdef SPECIAL_MASK_MODE_EN
    smm = 1'b0;
`endif
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic latch_clear(input logic [7:0] c);
    latch = 1'b1; clr = c;
    tick(1);
    latch = 1'b0; clr = '0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({interrupt, hlis, irr, isr} !== 32'h0) begin failures++;
      $display("FAIL reset_outputs got=%h exp=%h", {interrupt, hlis, irr, isr}, 32'h0); end
  endtask

  task automatic test_edge_request();
    do_reset();
    pin = 8'h04;
    tick(2);
    checks++; if (irr !== 8'h00) begin failures++;
      $display("FAIL edge_latency_2 got=%h exp=%h", irr, 8'h00); end
    tick(1);
    checks++; if (irr !== 8'h04) begin failures++;
      $display("FAIL edge_irr got=%h exp=%h", irr, 8'h04); end
    checks++; if (interrupt !== 8'h04) begin failures++;
      $display("FAIL edge_int got=%h exp=%h", interrupt, 8'h04); end
    latch_clear(8'h04);
    checks++; if ({isr, irr, hlis} !== 24'h040004) begin failures++;
      $display("FAIL edge_latch isr_irr_hlis got=%h exp=%h", {isr, irr, hlis}, 24'h040004); end
    checks++; if (interrupt !== 8'h00) begin failures++;
      $display("FAIL edge_int_after got=%h exp=%h", interrupt, 8'h00); end
  endtask

  task automatic test_rotation();
    do_reset();
    pin = 8'h28;
    tick(3);
    checks++; if (irr !== 8'h28) begin failures++;
      $display("FAIL rot_irr got=%h exp=%h", irr, 8'h28); end
    checks++; if (interrupt !== 8'h08) begin failures++;
      $display("FAIL rot7 got=%h exp=%h", interrupt, 8'h08); end
    rotate = 3'd3; #1;
    checks++; if (interrupt !== 8'h20) begin failures++;
      $display("FAIL rot3 got=%h exp=%h", interrupt, 8'h20); end
    rotate = 3'd5; #1;
    checks++; if (interrupt !== 8'h08) begin failures++;
      $display("FAIL rot5 got=%h exp=%h", interrupt, 8'h08); end
  endtask

  task automatic test_nesting();
    do_reset();
    pin = 8'h02;
    tick(3);
    latch_clear(8'h02);
    checks++; if (isr !== 8'h02) begin failures++;
      $display("FAIL nest_isr got=%h exp=%h", isr, 8'h02); end
    pin = 8'h0A;
    tick(3);
    checks++; if ({irr, interrupt} !== 16'h0800) begin failures++;
      $display("FAIL nest_lower irr_int got=%h exp=%h", {irr, interrupt}, 16'h0800); end
    pin = 8'h0B;
    tick(3);
    checks++; if ({irr, interrupt} !== 16'h0901) begin failures++;
      $display("FAIL nest_higher irr_int got=%h exp=%h", {irr, interrupt}, 16'h0901); end
    clr = 8'h09; tick(1); clr = '0;
    pin = 8'h00;
    tick(3);
    sfnm = 1'b1; pin = 8'h02;
    tick(3);
    checks++; if ({irr, interrupt} !== 16'h0202) begin failures++;
      $display("FAIL nest_sfnm irr_int got=%h exp=%h", {irr, interrupt}, 16'h0202); end
    sfnm = 1'b0; #1;
    checks++; if (interrupt !== 8'h00) begin failures++;
      $display("FAIL nest_equal_blocked got=%h exp=%h", interrupt, 8'h00); end
    eoi = 8'h02; tick(1); eoi = '0;
    checks++; if ({isr, interrupt} !== 16'h0002) begin failures++;
      $display("FAIL nest_eoi isr_int got=%h exp=%h", {isr, interrupt}, 16'h0002); end
  endtask

  task automatic test_mask_freeze();
    do_reset();
    mask = 8'h01; pin = 8'h01;
    tick(3);
    checks++; if ({irr, interrupt} !== 16'h0100) begin failures++;
      $display("FAIL mask_blocked irr_int got=%h exp=%h", {irr, interrupt}, 16'h0100); end
    mask = 8'h00; #1;
    checks++; if (interrupt !== 8'h01) begin failures++;
      $display("FAIL unmask got=%h exp=%h", interrupt, 8'h01); end
    clr = 8'h01; tick(1); clr = '0;
    freeze = 1'b1; pin = 8'h09;
    tick(4);
    checks++; if (irr !== 8'h00) begin failures++;
      $display("FAIL freeze_hold got=%h exp=%h", irr, 8'h00); end
    freeze = 1'b0;
    tick(2);
    checks++; if (irr !== 8'h00) begin failures++;
      $display("FAIL freeze_no_late got=%h exp=%h", irr, 8'h00); end
  endtask

  task automatic test_level_simultaneous();
    do_reset();
    level = 1'b1; pin = 8'h20;
    tick(2);
    checks++; if (irr !== 8'h00) begin failures++;
      $display("FAIL level_latency_2 got=%h exp=%h", irr, 8'h00); end
    tick(1);
    checks++; if (irr !== 8'h20) begin failures++;
      $display("FAIL level_irr got=%h exp=%h", irr, 8'h20); end
    clr = 8'h20; tick(1); clr = '0;
    checks++; if (irr !== 8'h00) begin failures++;
      $display("FAIL level_clear got=%h exp=%h", irr, 8'h00); end
    tick(1);
    checks++; if (irr !== 8'h20) begin failures++;
      $display("FAIL level_reset got=%h exp=%h", irr, 8'h20); end
    latch = 1'b1; eoi = 8'h20;
    tick(1);
    latch = 1'b0; eoi = '0;
    checks++; if (isr !== 8'h20) begin failures++;
      $display("FAIL latch_eoi_same got=%h exp=%h", isr, 8'h20); end
    pin = 8'h00;
    tick(2);
    checks++; if (irr !== 8'h20) begin failures++;
      $display("FAIL level_fall_2 got=%h exp=%h", irr, 8'h20); end
    tick(1);
    checks++; if (irr !== 8'h00) begin failures++;
      $display("FAIL level_fall got=%h exp=%h", irr, 8'h00); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    level = 1'b1; rotate = 3'd6; pin = 8'h81;
    tick(3);
    checks++; if (interrupt !== 8'h80) begin failures++;
      $display("FAIL mid_rot6 got=%h exp=%h", interrupt, 8'h80); end
    latch_clear(8'h80);
    checks++; if ({isr, irr, interrupt} !== 24'h800100) begin failures++;
      $display("FAIL mid_first isr_irr_int got=%h exp=%h", {isr, irr, interrupt}, 24'h800100); end
    rotate = 3'd7; #1;
    checks++; if (interrupt !== 8'h01) begin failures++;
      $display("FAIL mid_rot7 got=%h exp=%h", interrupt, 8'h01); end
    latch_clear(8'h01);
    pin = 8'h10;
    tick(3);
    checks++; if ({isr, irr, interrupt, hlis} !== 32'h81100001) begin failures++;
      $display("FAIL mid_setup isr_irr_int_hlis got=%h exp=%h", {isr, irr, interrupt, hlis}, 32'h81100001); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({interrupt, hlis, irr, isr} !== 32'h0) begin failures++;
      $display("FAIL mid_async_reset got=%h exp=%h", {interrupt, hlis, irr, isr}, 32'h0); end
    tick(1);
    reset = 1'b0;
    tick(2);
    checks++; if (irr !== 8'h00) begin failures++;
      $display("FAIL mid_relatency_2 got=%h exp=%h", irr, 8'h00); end
    tick(1);
    checks++; if (irr !== 8'h10) begin failures++;
      $display("FAIL mid_rerequest got=%h exp=%h", irr, 8'h10); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_edge_request();
    test_rotation();
    test_nesting();
    test_mask_freeze();
    test_level_simultaneous();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
